fetch_inst_queue: RTL and testbench

//  Instruction queue between the AXI read-data channel of the fetch unit and the decode stage.

---
 rtl/fetch_inst_queue.sv | 124 ++++++++++++
 tb/tb_fetch_inst_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_inst_queue.sv
// Instruction queue: splits 64-bit fetch read beats into two PC-tagged 32-bit instructions for decode.
// Latency: a beat accepted at edge N shows its low word at the output from the cycle after N.
// Backpressure: in_ready drops while fewer than two entries are free; out_ready never reaches in_ready.
// Optional: define FETCHQ_ZERO_HALT_EN to stop the queue on an all-zero head instruction.
module fetch_inst_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       line_start_valid,
  input  logic [ADDR_WIDTH-1:0]      line_start_pc,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_last,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INST_WIDTH-1:0]      out_inst,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       halt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state, state_nxt;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0]   cur_pc;
  logic [INST_WIDTH-1:0]   inst_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_mem   [DEPTH];
  logic                    push, pop, not_empty, halt_blk;

  assign not_empty = (count != '0);

`ifdef FETCHQ_ZERO_HALT_EN
  logic halt_q;
  logic head_zero;

  assign head_zero = not_empty && (inst_mem[rd_ptr] == '0);
  // Combinational term blocks the zero word in the very cycle it reaches the head.
  assign halt_blk  = halt_q || head_zero;
  assign halt      = halt_q;

  // Sticky halt: only reset clears it, flush leaves it set.
  always_ff @(posedge clk) begin
    if (!reset)         halt_q <= 1'b0;
    else if (head_zero) halt_q <= 1'b1;
  end
`else
  assign halt_blk = 1'b0;
  assign halt     = 1'b0;
`endif

  // Room for a full beat (two entries) is judged on the registered count only.
  assign in_ready  = (state == STREAM) && (count <= CW'(DEPTH - 2)) && !flush && reset && !halt_blk;
  assign out_valid = not_empty && !halt_blk;
  assign out_inst  = not_empty ? inst_mem[rd_ptr] : '0;
  assign out_pc    = not_empty ? pc_mem[rd_ptr]   : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a burst opens on line_start_valid and closes on its last accepted beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (line_start_valid)  state_nxt = STREAM;
      STREAM:  if (push && in_last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // PC of the next incoming beat's low word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_pc <= '0;
    end else if (!flush) begin
      if (state == IDLE && line_start_valid) cur_pc <= line_start_pc;
      else if (push)                         cur_pc <= cur_pc + ADDR_WIDTH'(8);
    end
  end

  // Pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(2);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(2);
        2'b01:   count <= count - CW'(1);
        2'b11:   count <= count + CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage: each accepted beat writes its low and high words into consecutive entries.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr]         <= in_data[INST_WIDTH-1:0];
      pc_mem[wr_ptr]           <= cur_pc;
      inst_mem[wr_ptr + PW'(1)] <= in_data[DATA_WIDTH-1:INST_WIDTH];
      pc_mem[wr_ptr + PW'(1)]   <= cur_pc + ADDR_WIDTH'(4);
    end
  end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed bench for fetch_inst_queue: vector table plus multi-cycle corner sequences.
module tb_fetch_inst_queue;

  logic        clk = 1'b0;
  logic        reset, line_start_valid, in_valid, in_ready, in_last, flush;
  logic        out_valid, out_ready, halt;
  logic [63:0] line_start_pc, in_data, out_pc;
  logic [31:0] out_inst;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_inst_queue dut (
    .clk(clk), .reset(reset), .line_start_valid(line_start_valid), .line_start_pc(line_start_pc),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .count(count), .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        lsv;
    logic [63:0] lpc;
    logic        iv;
    logic [63:0] id;
    logic        il;
    logic        fl;
    logic        ordy;
    logic        e_irdy;
    logic        e_ovld;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    line_start_valid = 1'b0; line_start_pc = '0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; flush = 1'b0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic start_line(input logic [63:0] pc);
    line_start_valid = 1'b1; line_start_pc = pc;
    tick();
    line_start_valid = 1'b0;
  endtask

  function automatic logic [63:0] beat(input int k);
    logic [31:0] lo, hi;
    lo = 32'h1000_0000 + 32'(2 * k);
    hi = lo + 32'd1;
    return {hi, lo};
  endfunction

  initial begin
    int nb, npop;
    idle_inputs();
    reset = 1'b0;

    // Table: {rst,lsv,lpc,iv,id,il,fl,ordy, exp in_ready,out_valid,out_inst,out_pc,count}
    vt[0] = '{1'b0, 1'b0, 64'h0,    1'b0, 64'h0,                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         64'h0,    4'd0};
    vt[1] = '{1'b1, 1'b1, 64'h1000, 1'b0, 64'h0,                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         64'h0,    4'd0};
    vt[2] = '{1'b1, 1'b0, 64'h0,    1'b1, 64'h2222_2222_1111_1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         64'h0,    4'd0};
    vt[3] = '{1'b1, 1'b0, 64'h0,    1'b1, 64'h4444_4444_3333_3333, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1111_1111, 64'h1000, 4'd2};
    vt[4] = '{1'b1, 1'b0, 64'h0,    1'b1, 64'h5555_5555_5555_5555, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2222_2222, 64'h1004, 4'd3};
    vt[5] = '{1'b1, 1'b0, 64'h0,    1'b0, 64'h0,                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3333_3333, 64'h1008, 4'd2};
    vt[6] = '{1'b1, 1'b0, 64'h0,    1'b0, 64'h0,                  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3333_3333, 64'h1008, 4'd2};
    vt[7] = '{1'b1, 1'b0, 64'h0,    1'b0, 64'h0,                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         64'h0,    4'd0};

    // Reset held for two edges, then reset-state outputs.
    tick();
    tick();
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_halt", 64'(halt), 64'd0);
    tick();

    for (int i = 0; i < 8; i++) begin
      reset = vt[i].rst; line_start_valid = vt[i].lsv; line_start_pc = vt[i].lpc;
      in_valid = vt[i].iv; in_data = vt[i].id; in_last = vt[i].il;
      flush = vt[i].fl; out_ready = vt[i].ordy;
      #2;
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vt[i].e_irdy));
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vt[i].e_ovld));
      chk($sformatf("vec%0d_out_inst", i), 64'(out_inst), 64'(vt[i].e_inst));
      chk($sformatf("vec%0d_out_pc", i), out_pc, vt[i].e_pc);
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].e_cnt));
      tick();
    end

    // Full 8-beat burst with decode always ready: 16 instructions in order.
    do_reset();
    start_line(64'h8000_0000);
    nb = 0; npop = 0;
    for (int c = 0; c < 100 && npop < 16; c++) begin
      in_valid = (nb < 8); in_data = beat(nb); in_last = (nb == 7); out_ready = 1'b1;
      #2;
      if (out_valid) begin
        chk($sformatf("burst_inst%0d", npop), 64'(out_inst), 64'(32'h1000_0000 + 32'(npop)));
        chk($sformatf("burst_pc%0d", npop), out_pc, 64'h8000_0000 + 64'(4 * npop));
        npop++;
      end
      if (in_valid && in_ready) nb++;
      tick();
    end
    chk("burst_pops", 64'(npop), 64'd16);
    chk("burst_beats", 64'(nb), 64'd8);
    in_valid = 1'b1; in_last = 1'b0;
    #2;
    chk("burst_idle_after_last", 64'(in_ready), 64'd0);
    tick();

    // Fill with decode stalled, then drain and watch in_ready return.
    do_reset();
    start_line(64'h0);
    nb = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1; in_data = beat(nb); in_last = 1'b0; out_ready = 1'b0;
      #2;
      if (in_valid && in_ready) nb++;
      tick();
    end
    chk("full_beats", 64'(nb), 64'd4);
    #2;
    chk("full_count", 64'(count), 64'd8);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    tick();
    out_ready = 1'b1;
    #2;
    chk("drain0_in_ready", 64'(in_ready), 64'd0);
    chk("drain0_inst", 64'(out_inst), 64'h1000_0000);
    chk("drain0_pc", out_pc, 64'h0);
    tick();
    #2;
    chk("drain1_count", 64'(count), 64'd7);
    chk("drain1_in_ready", 64'(in_ready), 64'd0);
    chk("drain1_inst", 64'(out_inst), 64'h1000_0001);
    chk("drain1_pc", out_pc, 64'h4);
    tick();
    #2;
    chk("drain2_count", 64'(count), 64'd6);
    chk("drain2_in_ready", 64'(in_ready), 64'd1);
    tick();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Simultaneous push and pop at count=5.
    do_reset();
    start_line(64'h200);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = beat(k);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b1; in_data = beat(3); out_ready = 1'b1;
    #2;
    chk("pp_count_before", 64'(count), 64'd5);
    chk("pp_pc_before", out_pc, 64'h204);
    chk("pp_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    chk("pp_count_after", 64'(count), 64'd6);
    chk("pp_pc_after", out_pc, 64'h208);

    // Flush with a beat presented at count=6, then restart at 0x100.
    in_valid = 1'b1; in_data = beat(9); flush = 1'b1;
    #2;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    in_valid = 1'b0; flush = 1'b0;
    #2;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    tick();
    start_line(64'h100);
    in_valid = 1'b1; in_data = 64'h0000_00AA_0000_0055; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    #2;
    chk("restart_out_valid", 64'(out_valid), 64'd1);
    chk("restart_pc", out_pc, 64'h100);
    chk("restart_inst", 64'(out_inst), 64'h55);
    tick();

    // Zero-word instruction handling.
    do_reset();
    start_line(64'h300);
    in_valid = 1'b1; in_data = 64'h0000_0000_0000_0013; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #2;
    chk("zero_addi_valid", 64'(out_valid), 64'd1);
    chk("zero_addi_inst", 64'(out_inst), 64'h13);
    chk("zero_addi_pc", out_pc, 64'h300);
    tick();
    #2;
`ifdef FETCHQ_ZERO_HALT_EN
    chk("zero_blocked_valid", 64'(out_valid), 64'd0);
    tick();
    #2;
    chk("zero_halt", 64'(halt), 64'd1);
    chk("zero_halt_valid", 64'(out_valid), 64'd0);
`else
    chk("zero_pass_valid", 64'(out_valid), 64'd1);
    chk("zero_pass_inst", 64'(out_inst), 64'h0);
    chk("zero_pass_pc", out_pc, 64'h304);
    chk("zero_pass_halt", 64'(halt), 64'd0);
    tick();
    #2;
    chk("zero_pass_count", 64'(count), 64'd0);
    chk("zero_pass_halt2", 64'(halt), 64'd0);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
